irq_controller: RTL
===================

Name: irq_controller

Overview:
Memory-mapped interrupt controller on the processor memory bus. It consumes per-peripheral event lines such as the timer's threshold_trigger and latches them as pending bits. It masks and prioritises them and drives a single registered interrupt request plus source ID to the core. Software configures, claims and completes interrupts through word-sized registers on the same request/response interface as the other peripherals.

Parameters:
ADDR_START, 0, byte base address of the register window (ADDR_W bits)
NUM_SRC, 8, number of interrupt source lines (1..31)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_irq_src  input  NUM_SRC  event lines, synchronous to clk
i_req_addr  input  ADDR_W  request byte address
i_req_wr_data  input  WORD_W  write data
i_req_wr_en  input  1  1 = write, 0 = read
i_req_count  input  MEM_COUNT_W  access size
o_res_rd_data  output  WORD_W  read data (combinational)
o_res_code  output  MEM_CODE_W  response code (combinational)
o_irq  output  1  registered interrupt request to core
o_irq_id  output  5  registered ID (index+1) of winning source, 0 when none

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Register map (byte offset from ADDR_START, bits [NUM_SRC-1:0] unless noted, unused bits read 0):
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: read returns the pending bits; write is write-1-to-clear.
  - 0x08 EDGE: RW; 1 = rising-edge source, 0 = level source.
  - 0x0C CLAIM: read returns the ID of the highest-priority pending&enabled source (lowest index wins, ID = index+1), or 0 if none; reading does not clear anything. Writing k in 1..NUM_SRC clears pending[k-1]; any other value is ignored but still gets a write-success code.
  - 0x10 GLOBAL: RW, bit0 only.
- Access rules:
  - Only aligned full-word accesses are legal: addr[1:0]==0 and i_req_count==MEM_COUNT_WORD.
  - Any other access inside the window returns MEM_CODE_INVALID and changes no state.
  - An address outside [ADDR_START, ADDR_START+0x13] drives o_res_rd_data and o_res_code to 'bz (shared bus convention).
  - A legal read returns MEM_CODE_READ_OK with combinational data. A legal write returns MEM_CODE_WRITE_OK and takes effect at the next clk edge.
- Source capture:
  - src_prev register holds i_irq_src from the previous cycle.
  - Edge source: set pending[i] when i_irq_src[i] & ~src_prev[i].
  - Level source: set pending[i] every cycle i_irq_src[i]==1.
  - Pending is latched regardless of ENABLE and GLOBAL.
- Set/clear collision: set wins over a W1C or CLAIM clear in the same cycle. A level source held high therefore re-pends on the cycle after a clear.
- Output:
  - Each edge, o_irq <= GLOBAL[0] & |(PENDING & ENABLE) and o_irq_id <= the claim ID, both computed from current register values.
  - Latency: source sampled at edge E0 → PENDING visible after E0 → o_irq after E1.
  - A clear written at edge E0 drops o_irq after E1 if nothing else is pending.
- Reset: ENABLE, PENDING, EDGE, GLOBAL, src_prev, o_irq and o_irq_id all 0. Reset overrides any write or capture in the same cycle.
- After reset release: an edge source already high is detected as a rising edge on the first cycle, because src_prev is 0.
- EDGE reconfiguration does not alter existing pending bits.

Decomposition:
- Shared package/header holds:
  - ADDR_W, WORD_W, MEM_COUNT_W, MEM_CODE_W;
  - MEM_COUNT_WORD;
  - MEM_CODE_READ_OK, MEM_CODE_WRITE_OK, MEM_CODE_INVALID;
  - the IRQ register offsets 0x00–0x10.
- One sub-module: irq_priority_encoder. It is a combinational lowest-index-first encoder: NUM_SRC-bit vector in, 5-bit ID out, 0 when the vector is empty.

Test Plan:
1. Reset asserted 2 cycles → reads of 0x00–0x10 return 0 with MEM_CODE_READ_OK; o_irq=0, o_irq_id=0.
2. EDGE=0x01, ENABLE=0x01, GLOBAL=1, then a 1-cycle pulse on src[0] → PENDING=0x01 after E0; o_irq=1 and o_irq_id=1 after E1; CLAIM read=1. Writing 1 to CLAIM → PENDING=0, and o_irq=0 one edge later.
3. Level src[2] held high, ENABLE=0x04 → W1C 0x04 to PENDING; PENDING reads 0x04 again on the next cycle and o_irq stays 1.
4. Edge pulses on src[3] and src[5] in the same cycle, ENABLE=0x28 → CLAIM=4 and o_irq_id=4. Complete with 4 → CLAIM=6 and o_irq_id=6 one edge later.
5. ENABLE=0 with a pulse on src[1] → PENDING=0x02 and o_irq stays 0. Write ENABLE=0x02 → o_irq=1 one edge after the write takes effect.
6. Write at offset 0x02, or with a non-word count → MEM_CODE_INVALID and no register change. Read at ADDR_START+0x20 → data and code are 'bz. A W1C that coincides with a rising edge on the same source → pending stays 1.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared bus widths, response codes and register offsets for the interrupt controller.
// The word index of a register is its byte offset divided by four.
package irq_controller_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

  // Nonzero codes so a floating (undriven) bus never looks like a valid response.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ_OK  = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE_OK = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID  = 2'd3;

  localparam logic [4:0] IRQ_OFF_ENABLE  = 5'h00;
  localparam logic [4:0] IRQ_OFF_PENDING = 5'h04;
  localparam logic [4:0] IRQ_OFF_EDGE    = 5'h08;
  localparam logic [4:0] IRQ_OFF_CLAIM   = 5'h0C;
  localparam logic [4:0] IRQ_OFF_GLOBAL  = 5'h10;
  localparam logic [4:0] IRQ_WIN_BYTES   = 5'h14;

  typedef enum logic [2:0] {
    REG_ENABLE  = 3'd0,
    REG_PENDING = 3'd1,
    REG_EDGE    = 3'd2,
    REG_CLAIM   = 3'd3,
    REG_GLOBAL  = 3'd4
  } irq_reg_e;

endpackage

// File: rtl/irq_controller_priority_encoder.sv
// Lowest-index-first encoder: returns index+1 of the first set bit, 0 when empty.
module irq_priority_encoder #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic [4:0]         id_o
);

  // Scan downwards so the lowest set index is the last assignment to stick.
  always_comb begin
    id_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec_i[i]) id_o = 5'(i + 1);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches event lines as pending bits, masks and
// prioritises them, and drives a registered request plus source ID to the core.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_START = '0,
  parameter int                NUM_SRC    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     i_irq_src,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [WORD_W-1:0]      i_req_wr_data,
  input  logic                   i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_req_count,
  output logic [WORD_W-1:0]      o_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_res_code,
  output logic                   o_irq,
  output logic [4:0]             o_irq_id
);

  logic [NUM_SRC-1:0] enable_q,  enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] edge_q,    edge_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic               global_q,  global_d;
  logic               irq_q,     irq_d;
  logic [4:0]         irq_id_q;

  logic [ADDR_W-1:0]  offset;
  logic               in_window;
  logic               legal;
  logic               wr_ok;
  irq_reg_e           reg_sel;
  logic [NUM_SRC-1:0] masked;
  logic [4:0]         claim_id;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [WORD_W-1:0]  rd_word;

  // Unsigned wrap makes addresses below ADDR_START land far outside the window.
  assign offset    = i_req_addr - ADDR_START;
  assign in_window = offset < ADDR_W'(IRQ_WIN_BYTES);
  assign legal     = in_window && (offset[1:0] == 2'b00) && (i_req_count == MEM_COUNT_WORD);
  assign wr_ok     = legal && i_req_wr_en;
  assign reg_sel   = irq_reg_e'(offset[4:2]);

  assign masked = pending_q & enable_q;

  irq_priority_encoder #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .vec_i (masked),
    .id_o  (claim_id)
  );

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_ENABLE:  rd_word[NUM_SRC-1:0] = enable_q;
      REG_PENDING: rd_word[NUM_SRC-1:0] = pending_q;
      REG_EDGE:    rd_word[NUM_SRC-1:0] = edge_q;
      REG_CLAIM:   rd_word[4:0]         = claim_id;
      REG_GLOBAL:  rd_word[0]           = global_q;
      default:     rd_word              = '0;
    endcase
  end

  assign o_res_rd_data = !in_window ? 'z :
                         (legal && !i_req_wr_en) ? rd_word : '0;

  assign o_res_code = !in_window   ? 'z :
                      !legal       ? MEM_CODE_INVALID :
                      i_req_wr_en  ? MEM_CODE_WRITE_OK : MEM_CODE_READ_OK;

  assign set_vec = (edge_q & i_irq_src & ~src_prev_q) | (~edge_q & i_irq_src);

  always_comb begin
    clr_vec = '0;
    if (wr_ok && reg_sel == REG_PENDING) clr_vec = i_req_wr_data[NUM_SRC-1:0];
    if (wr_ok && reg_sel == REG_CLAIM) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i_req_wr_data == WORD_W'(i + 1)) clr_vec[i] = 1'b1;
      end
    end
  end

  // A new event in the same cycle as a clear keeps the bit pending.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    global_d = global_q;
    if (wr_ok) begin
      case (reg_sel)
        REG_ENABLE: enable_d = i_req_wr_data[NUM_SRC-1:0];
        REG_EDGE:   edge_d   = i_req_wr_data[NUM_SRC-1:0];
        REG_GLOBAL: global_d = i_req_wr_data[0];
        default:    ;
      endcase
    end
  end

  assign irq_d = global_q & (|masked);

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= '0;
      pending_q  <= '0;
      edge_q     <= '0;
      global_q   <= 1'b0;
      src_prev_q <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      edge_q     <= edge_d;
      global_q   <= global_d;
      src_prev_q <= i_irq_src;
      irq_q      <= irq_d;
      irq_id_q   <= claim_id;
    end
  end

  assign o_irq    = irq_q;
  assign o_irq_id = irq_id_q;

endmodule
